score_bcd_ctrl: RTL and testbench

- Owns the game score register and sequences its conversion to six BCD digits for the seven-segment display.
- Game logic posts line-clear events; the block adds level-scaled points (saturating) and then runs an iterative shift-add-3 conversion, one bit per cycle.
- The displayed digits are held stable between commits.
- Sits between the line-clear detector and the HEX display drivers.

---
 rtl/score_bcd_ctrl_pkg.sv | 36 +++
 rtl/score_bcd_ctrl_dd_step.sv | 28 ++
 rtl/score_bcd_ctrl.sv | 136 +++++++++++++
 tb/tb_score_bcd_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_bcd_ctrl_pkg.sv
// Shared types and constants for the score register / BCD display controller.
package score_bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int BASE_W     = 11;   // widest base value is 1200
  localparam int PTS_W      = 15;   // 1200 * 16 = 19200

  localparam int PTS_1 = 40;
  localparam int PTS_2 = 100;
  localparam int PTS_3 = 300;
  localparam int PTS_4 = 1200;

  // Ceiling that still fits six decimal digits.
  localparam int SCORE_SAT_MAX = 999999;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_t;

  // Base points for a line-clear event; zero marks an illegal line count.
  function automatic logic [BASE_W-1:0] base_pts(input logic [2:0] lines);
    case (lines)
      3'd1:    return BASE_W'(PTS_1);
      3'd2:    return BASE_W'(PTS_2);
      3'd3:    return BASE_W'(PTS_3);
      3'd4:    return BASE_W'(PTS_4);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/score_bcd_ctrl_dd_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift the digit
// chain left by one with bit_i entering the ones digit.
module score_bcd_ctrl_dd_step
  import score_bcd_ctrl_pkg::*;
(
  input  bcd_t digits_i,
  input  logic bit_i,
  output bcd_t digits_o
);

  logic [NUM_DIGITS-1:0] ge5;
  logic [NUM_DIGITS-1:0] cin;

  assign cin[0] = bit_i;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic [DIGIT_W-2:0] lo;
    assign ge5[d] = (digits_i[d] >= DIGIT_W'(5));
    // Low three bits of the adjusted digit; a digit >= 5 always becomes >= 8,
    // so the adjusted MSB (carried into the next digit) is simply ge5.
    assign lo = digits_i[d][DIGIT_W-2:0] + (ge5[d] ? 3'd3 : 3'd0);
    assign digits_o[d] = {lo, cin[d]};
    if (d > 0) begin : g_carry
      assign cin[d] = ge5[d-1];
    end
  end

endmodule

// File: rtl/score_bcd_ctrl.sv
// Game score register with saturating level-scaled adds and an iterative
// binary-to-BCD conversion that commits six display digits atomically.
module score_bcd_ctrl
  import score_bcd_ctrl_pkg::*;
#(
  parameter int SCORE_W   = 20,
  parameter int SCORE_MAX = SCORE_SAT_MAX
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               add_valid,
  input  logic [2:0]         lines,
  input  logic [3:0]         level,
  input  logic               clear,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         hundred_thousands,
  output logic [3:0]         ten_thousands,
  output logic [3:0]         thousands,
  output logic [3:0]         hundreds,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic               busy,
  output logic               update_done
);

  localparam int CNT_W = $clog2(SCORE_W);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dirty_q, dirty_d;
  logic               done_q, done_d;
  bcd_t               work_q, work_d;
  bcd_t               disp_q, disp_d;

  logic [BASE_W-1:0]  base;
  logic [PTS_W-1:0]   pts;
  logic [SCORE_W:0]   sum;
  logic               add_ok;
  bcd_t               step_digits;

  // Points for the incoming event and the unsaturated sum (one bit wider).
  always_comb begin
    base   = base_pts(lines);
    add_ok = add_valid && (base != '0);
    pts    = PTS_W'(base) * PTS_W'({1'b0, level} + 5'd1);
    sum    = {1'b0, score_q} + (SCORE_W+1)'(pts);
  end

  // Score next-state: clear beats add; adds saturate at SCORE_MAX.
  always_comb begin
    score_d = score_q;
    if (clear)
      score_d = '0;
    else if (add_ok)
      score_d = (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                : sum[SCORE_W-1:0];
  end

  score_bcd_ctrl_dd_step u_step (
    .digits_i (work_q),
    .bit_i    (shift_q[SCORE_W-1]),
    .digits_o (step_digits)
  );

  // Conversion FSM: snapshot in IDLE, SCORE_W shift steps, then commit.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    shift_d = shift_q;
    work_d  = work_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          shift_d = score_q;
          work_d  = '0;
          dirty_d = 1'b0;
          cnt_d   = CNT_W'(SCORE_W-1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = step_digits;
        shift_d = {shift_q[SCORE_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = work_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new event always leaves a conversion pending, even on the snapshot edge.
    if (clear || add_ok) dirty_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      score_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
      work_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      done_q  <= done_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
    end
  end

  assign score             = score_q;
  assign hundred_thousands = disp_q[5];
  assign ten_thousands     = disp_q[4];
  assign thousands         = disp_q[3];
  assign hundreds          = disp_q[2];
  assign tens              = disp_q[1];
  assign ones              = disp_q[0];
  assign busy              = (state_q != IDLE);
  assign update_done       = done_q;

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Scoreboard bench for score_bcd_ctrl: expected commit values are queued when
// stimulus is driven and popped whenever update_done is seen.
module tb_score_bcd_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        add_valid;
  logic [2:0]  lines;
  logic [3:0]  level;
  logic        clear;
  logic [19:0] score;
  logic [3:0]  hundred_thousands, ten_thousands, thousands, hundreds, tens, ones;
  logic        busy;
  logic        update_done;
  logic [23:0] disp;

  int vectors     = 0;
  int miscompares = 0;
  int model_score = 0;
  int done_cnt    = 0;
  int sb[$];

  always #5 clk = ~clk;

  score_bcd_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .add_valid         (add_valid),
    .lines             (lines),
    .level             (level),
    .clear             (clear),
    .score             (score),
    .hundred_thousands (hundred_thousands),
    .ten_thousands     (ten_thousands),
    .thousands         (thousands),
    .hundreds          (hundreds),
    .tens              (tens),
    .ones              (ones),
    .busy              (busy),
    .update_done       (update_done)
  );

  assign disp = {hundred_thousands, ten_thousands, thousands, hundreds, tens, ones};

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pts_of(input int l, input int lv);
    int b;
    case (l)
      1: b = 40;
      2: b = 100;
      3: b = 300;
      4: b = 1200;
      default: b = 0;
    endcase
    return b * (lv + 1);
  endfunction

  // Advance one cycle; sample #1 after the edge and retire a commit if one shows.
  task automatic tick();
    @(posedge clk); #1;
    if (update_done) begin
      done_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL commit_unexpected: got update_done with digits %h, required none", disp);
      end else begin
        int e;
        e = sb.pop_front();
        if (disp !== to_bcd(e)) begin
          miscompares++;
          $display("FAIL commit_digits: got %h, required %h", disp, to_bcd(e));
        end
      end
    end
  endtask

  task automatic pulse_add(input int l, input int lv);
    add_valid = 1'b1; lines = 3'(l); level = 4'(lv);
    tick();
    add_valid = 1'b0; lines = '0; level = '0;
    if (l >= 1 && l <= 4) begin
      model_score += pts_of(l, lv);
      if (model_score > 999999) model_score = 999999;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_score = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy || sb.size() != 0) begin
      miscompares++;
      $display("FAIL wait_idle: still busy=%0b with %0d commits outstanding after %0d cycles, required idle",
               busy, sb.size(), n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; add_valid = 1'b0; clear = 1'b0; lines = '0; level = '0;
    #12;
    vectors++;
    if (score !== 20'd0) begin miscompares++; $display("FAIL reset_score: got %0d, required 0", score); end
    vectors++;
    if (disp !== 24'h0) begin miscompares++; $display("FAIL reset_digits: got %h, required 000000", disp); end
    vectors++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got busy=%b done=%b, required 0 0", busy, update_done);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    int d0;
    bit found;
    d0 = done_cnt;
    pulse_add(1, 0);
    vectors++;
    if (score !== 20'(model_score)) begin miscompares++; $display("FAIL single_score: got %0d, required %0d", score, model_score); end
    sb.push_back(model_score);
    n = 0; found = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b after snapshot, required 1", busy); end
      end
      if (update_done) found = 1;
    end
    vectors++;
    if (!found || n != 22) begin miscompares++; $display("FAIL single_latency: got %0d cycles (seen=%0b), required 22", n, found); end
    repeat (30) tick();
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL single_pulses: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_saturate();
    pulse_clear();
    sb.push_back(0);
    wait_idle(60);
    for (int k = 1; k <= 54; k++) begin
      pulse_add(4, 15);
      sb.push_back(model_score);
      vectors++;
      if (score !== 20'(model_score)) begin miscompares++; $display("FAIL sat_score_%0d: got %0d, required %0d", k, score, model_score); end
      if (k == 52) begin
        vectors++;
        if (score !== 20'd998400) begin miscompares++; $display("FAIL sat_52: got %0d, required 998400", score); end
      end
      if (k == 53) begin
        vectors++;
        if (score !== 20'd999999) begin miscompares++; $display("FAIL sat_53: got %0d, required 999999", score); end
      end
      repeat (29) tick();
    end
    wait_idle(60);
    vectors++;
    if (disp !== 24'h999999) begin miscompares++; $display("FAIL sat_digits: got %h, required 999999", disp); end
  endtask

  task automatic test_back_to_back();
    int d0;
    pulse_clear();
    sb.push_back(0);
    wait_idle(60);
    d0 = done_cnt;
    pulse_add(2, 0);
    sb.push_back(model_score);
    repeat (4) tick();
    pulse_add(3, 0);
    sb.push_back(model_score);
    wait_idle(100);
    vectors++;
    if (done_cnt - d0 != 2 || score !== 20'd400) begin
      miscompares++; $display("FAIL b2b_pair: got %0d pulses score %0d, required 2 pulses score 400", done_cnt - d0, score);
    end
    // Several adds during one conversion coalesce into one follow-up.
    d0 = done_cnt;
    pulse_add(1, 0);
    sb.push_back(model_score);
    repeat (3) tick();
    pulse_add(1, 0);
    repeat (5) tick();
    pulse_add(1, 1);
    sb.push_back(model_score);
    wait_idle(100);
    vectors++;
    if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_coalesce: got %0d pulses, required 2", done_cnt - d0); end
    // Add landing on the snapshot edge must still leave a conversion pending.
    pulse_add(1, 0);
    sb.push_back(model_score);
    pulse_add(2, 0);
    sb.push_back(model_score);
    wait_idle(100);
    vectors++;
    if (score !== 20'd700) begin miscompares++; $display("FAIL b2b_snapedge: got %0d, required 700", score); end
  endtask

  task automatic test_clear_priority();
    pulse_clear();
    sb.push_back(0);
    wait_idle(60);
    pulse_add(4, 0);
    sb.push_back(model_score);
    wait_idle(60);
    pulse_add(1, 0);
    sb.push_back(model_score);
    wait_idle(60);
    vectors++;
    if (score !== 20'd1240) begin miscompares++; $display("FAIL clr_setup: got %0d, required 1240", score); end
    clear = 1'b1; add_valid = 1'b1; lines = 3'd4; level = 4'd0;
    tick();
    clear = 1'b0; add_valid = 1'b0; lines = '0;
    model_score = 0;
    sb.push_back(0);
    vectors++;
    if (score !== 20'd0) begin miscompares++; $display("FAIL clr_wins: got %0d, required 0", score); end
    wait_idle(60);
    vectors++;
    if (disp !== 24'h0) begin miscompares++; $display("FAIL clr_digits: got %h, required 000000", disp); end
  endtask

  task automatic test_illegal();
    int d0;
    pulse_add(3, 2);
    sb.push_back(model_score);
    wait_idle(60);
    d0 = done_cnt;
    pulse_add(0, 3);
    pulse_add(5, 3);
    pulse_add(7, 15);
    vectors++;
    if (score !== 20'(model_score) || model_score != 900) begin
      miscompares++; $display("FAIL illegal_score: got %0d, required 900", score);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL illegal_busy: got %b at cycle %0d, required 0", busy, i); end
    end
    vectors++;
    if (done_cnt != d0) begin miscompares++; $display("FAIL illegal_done: got %0d pulses, required 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    pulse_add(1, 0);
    sb.push_back(model_score);
    repeat (8) tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_pre: got %b, required 1", busy); end
    resetn = 1'b0;
    #1;
    vectors++;
    if (score !== 20'd0 || busy !== 1'b0 || disp !== 24'h0 || update_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state: got score=%0d busy=%b digits=%h done=%b, required 0 0 000000 0",
               score, busy, disp, update_done);
    end
    sb.delete();
    model_score = 0;
    d0 = done_cnt;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (30) tick();
    vectors++;
    if (done_cnt != d0 || score !== 20'd0) begin
      miscompares++; $display("FAIL rstmid_after: got %0d pulses score %0d, required 0 pulses score 0", done_cnt - d0, score);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_back_to_back();
    test_clear_priority();
    test_illegal();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
